// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS Avalon bus master: size codes, FSM states,
// grant identifiers, and alignment/byte-lane helpers.
package mips_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccI,
        StAccD,
        StDone
    } state_e;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_e;

    // Size code 2'b11 is illegal and reported the same way as a misaligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mips_bus_lanes.sv
// Combinational byte-lane logic: replicates store data across lanes and extracts,
// right-justifies and extends sub-word load data.
module mips_bus_lanes
    import mips_bus_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_lanes,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be = byte_enables(st_size, st_offset);
        case (st_size)
            SZ_BYTE: st_lanes = {4{st_wdata[7:0]}};
            SZ_HALF: st_lanes = {2{st_wdata[15:0]}};
            default: st_lanes = st_wdata;
        endcase
    end

    always_comb begin
        case (ld_offset)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mips_avalon_bus_master.sv
// Avalon-MM master arbitrating MIPS instruction fetches and data accesses, one
// transaction at a time, with fully registered outputs.
module mips_avalon_bus_master
    import mips_bus_pkg::*;
#(
    parameter bit RESET_GRANT_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d, grant;
    logic   grant_bad;
    logic   armed_q, armed_d;
    logic   we_q, we_d, signed_q, signed_d;
    logic [1:0] size_q, size_d, offset_q, offset_d;

    logic [31:0] address_d, writedata_d, i_rdata_d, d_rdata_d;
    logic [3:0]  byteenable_d;
    logic        read_d, write_d, i_ready_d, d_ready_d, i_err_d, d_err_d;

    logic [31:0] st_lanes, ld_data;
    logic [3:0]  st_be;

    mips_bus_lanes u_lanes (
        .st_size   (d_size),
        .st_offset (d_addr[1:0]),
        .st_wdata  (d_wdata),
        .st_lanes  (st_lanes),
        .st_be     (st_be),
        .ld_size   (size_q),
        .ld_offset (offset_q),
        .ld_signed (signed_q),
        .ld_rdata  (readdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        if (i_req && d_req) begin
            grant = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            grant = GRANT_D;
        end else begin
            grant = GRANT_I;
        end
        grant_bad = (grant == GRANT_I) ? misaligned(SZ_WORD, i_addr[1:0])
                                       : misaligned(d_size, d_addr[1:0]);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        armed_d      = armed_q;
        we_d         = we_q;
        signed_d     = signed_q;
        size_d       = size_q;
        offset_d     = offset_q;
        address_d    = address;
        writedata_d  = writedata;
        byteenable_d = byteenable;
        read_d       = read;
        write_d      = write;
        i_rdata_d    = i_rdata;
        d_rdata_d    = d_rdata;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_err_d      = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            StIdle: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (i_req || d_req) begin
                    last_grant_d = grant;
                    armed_d      = 1'b0;
                    if (grant_bad) begin
                        state_d = StDone;
                        if (grant == GRANT_I) begin
                            i_ready_d = 1'b1;
                            i_err_d   = 1'b1;
                        end else begin
                            d_ready_d = 1'b1;
                            d_err_d   = 1'b1;
                        end
                    end else if (grant == GRANT_I) begin
                        state_d      = StAccI;
                        address_d    = {i_addr[31:2], 2'b00};
                        byteenable_d = 4'b1111;
                        read_d       = 1'b1;
                    end else begin
                        state_d   = StAccD;
                        address_d = {d_addr[31:2], 2'b00};
                        we_d      = d_we;
                        signed_d  = d_signed;
                        size_d    = d_size;
                        offset_d  = d_addr[1:0];
                        if (d_we) begin
                            write_d      = 1'b1;
                            writedata_d  = st_lanes;
                            byteenable_d = st_be;
                        end else begin
                            read_d       = 1'b1;
                            byteenable_d = 4'b1111;
                        end
                    end
                end
            end
            StAccI, StAccD: begin
                // The first cycle of a bus access is an address phase; the
                // slave's waitrequest is honoured from the second cycle on.
                armed_d = 1'b1;
                if (armed_q && !waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = StDone;
                    if (state_q == StAccI) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = readdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = ld_data;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= RESET_GRANT_DATA ? GRANT_I : GRANT_D;
            armed_q      <= 1'b0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= SZ_WORD;
            offset_q     <= 2'b00;
            address      <= '0;
            writedata    <= '0;
            byteenable   <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            i_err        <= 1'b0;
            d_err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            armed_q      <= armed_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            address      <= address_d;
            writedata    <= writedata_d;
            byteenable   <= byteenable_d;
            read         <= read_d;
            write        <= write_d;
            i_rdata      <= i_rdata_d;
            d_rdata      <= d_rdata_d;
            i_ready      <= i_ready_d;
            d_ready      <= d_ready_d;
            i_err        <= i_err_d;
            d_err        <= d_err_d;
        end
    end

endmodule

// File: doc/mips_avalon_bus_master.md
Name: mips_avalon_bus_master

Overview:
- CPU-side Avalon memory-mapped master that sits directly upstream of the memory slave.
- Accepts independent instruction-fetch and data load/store requests from the MIPS core and arbitrates between them, one transaction at a time.
- Drives a single Avalon port: holds outputs stable under waitrequest, steers byte lanes for sub-word stores, and extracts/extends sub-word load data.
- Returns completion pulses and data to the core.

Parameters:
- RESET_GRANT_DATA, 1, when both requesters are pending on the first arbitration after reset, data wins.

Ports:
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request (level, held until i_ready)
- i_addr  in  32  fetch byte address
- i_ready  out  1  one-cycle completion pulse
- i_rdata  out  32  fetched word; valid with i_ready, held until the next fetch completion
- i_err  out  1  misaligned fetch; pulses with i_ready
- d_req  in  1  data request (level, held until d_ready)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as an error
- d_signed  in  1  sign-extend sub-word loads
- d_wdata  in  32  store data, right-justified
- d_ready  out  1  one-cycle completion pulse
- d_rdata  out  32  load result, right-justified and extended; held until the next data completion
- d_err  out  1  misaligned access or illegal size; pulses with d_ready
- address  out  32  Avalon word-aligned byte address (bits [1:0] = 0)
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte enables
- waitrequest  in  1  Avalon wait
- readdata  in  32  Avalon read data

Behaviour:
- Reset values: read, write, i_ready, d_ready, i_err, d_err = 0. address, writedata, i_rdata, d_rdata = 0. byteenable = 0. FSM = IDLE. last_grant = instr when RESET_GRANT_DATA = 1.
- All outputs are registered.
- FSM states: IDLE, ACC_I, ACC_D, DONE.
- IDLE, no request pending: read = write = 0.
- IDLE, only one request pending: grant that requester.
- IDLE, both pending: grant the requester opposite last_grant (round-robin); update last_grant.
- Misaligned grant (fetch with i_addr[1:0] != 0; half with d_addr[0] = 1; word with d_addr[1:0] != 0; or d_size = 11):
  - No bus cycle is issued; FSM goes to DONE.
  - Next cycle: ready and err pulse together; rdata is unchanged.
- Aligned grant: on the next edge, load address = addr & ~3 and set read or write. FSM goes to ACC_I or ACC_D.
- ACC_x, waitrequest = 1: address, read, write, writedata and byteenable are held bit-stable.
- ACC_x, waitrequest = 0 at an edge: the transfer completes.
  - Deassert read/write on that edge.
  - Capture readdata (after extraction) into i_rdata or d_rdata.
  - Pulse ready on that same edge; FSM goes to DONE.
- DONE: one cycle with ready = 0, then back to IDLE. This lets the requester drop or renew req, so a still-high req is never double-served.
- Minimum latency, aligned access with waitrequest low on first sample: req seen at edge N; read high N..N+1; ready high N+2..N+3; next grant at edge N+4.
- Store lane steering:
  - byte: byteenable = 1 << addr[1:0]; writedata = {4{wdata[7:0]}}.
  - half: byteenable = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}.
  - word: byteenable = 1111; writedata = wdata.
- Loads always use byteenable = 1111. d_rdata is the selected byte or half shifted to bit 0, then zero- or sign-extended per d_signed. Fetch returns the full word.
- read and write are never high together.
- Changes to i_*/d_* inputs while ACC_x is in progress are ignored; they are latched at grant.
- Reset during ACC_x: bus outputs drop on the reset edge, no ready is pulsed, FSM goes to IDLE, and rdata registers clear.

Decomposition:
- Package mips_bus_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - grant enum (GRANT_I/GRANT_D)
  - functions misaligned(), byte_enables()
- Sub-module mips_bus_lanes (combinational): store-lane steering and load extraction/extension. The top level holds the FSM, arbitration and registers.

Test Plan:
- Bench slave has waitrequest low on first sample. d_req load word at 0x10, memory = 0xDEADBEEF:
  - read high 2 cycles, address = 0x10, byteenable = 1111
  - d_ready pulse at N+2, d_rdata = 0xDEADBEEF
- Slave wait of 3 cycles, store byte 0x5A at 0x13:
  - writedata = 0x5A5A5A5A, byteenable = 1000, held stable for all wait cycles
  - one d_ready pulse; slave word becomes 0x5AxxXXXX
- Load half signed at 0x22, word 0x8001_7FFF → d_rdata = 0xFFFF8001. Same with d_signed = 0 → 0x00008001.
- Word store at 0x06 → no read/write ever asserted; d_ready = d_err = 1 for one cycle; d_rdata unchanged.
- i_req (0xBFC00000) and d_req both held high from reset:
  - data is granted first, then the fetch, alternating
  - never two grants to the same requester while the other is pending
- Reset asserted mid-ACC_I with waitrequest high → read = 0 after that edge, no i_ready, FSM in IDLE.
